irq_ctrl_multi: RTL and testbench
=================================

# irq_ctrl_multi

Parametrised, multi-source interrupt controller that replaces the single-source keyboard interrupt latch on the board top. It runs in the `CLOCK_50` domain. It latches up to `NUM_SRC` interrupt requests, which are either edge- or level-type per source, and applies an enable mask. It presents the lowest-numbered enabled pending source to the CPU as `interrupt_vector` and tracks the claim → in-service → end-of-interrupt (EOI) sequence. Software reaches pending, enable, status, EOI and soft-trigger registers over the system bus.

## Interface
Parameters:
- `NUM_SRC`, default 8: number of sources, range 1..15.
- `VEC_W`, default 4: vector width. Must satisfy 2^VEC_W > NUM_SRC. A vector value of 0 means no interrupt.
- `EDGE_SRC`, default all ones: per-source type. 1 = rising-edge latched, 0 = level.
- `EN_RESET`, default all ones: reset value of the ENABLE register.

Ports:
- `clk` in 1: system clock (`CLOCK_50`).
- `reset` in 1: asynchronous, active-high reset.
- `irq_src` in NUM_SRC: request lines, synchronous to `clk`. Bit i maps to vector i+1.
- `interrupt_vector` out VEC_W: registered vector presented to the CPU.
- `interrupt_ack` in 1: CPU acknowledge. Treated as a level that may be held for many `clk` cycles (the CPU runs on a slow clock).
- `reg_addr` in 3: register word index.
- `reg_wr` in 1: register write strobe.
- `reg_wdata` in 64: write data. Only bits [NUM_SRC-1:0] are used.
- `reg_rd` in 1: register read strobe.
- `reg_rdata` out 64: read data. Combinational from registers; 0 when `reg_rd` is low.

## Operation
Registers:
- 0 PENDING: read returns the pending vector. A write clears, for each set bit, the pending bit of edge-type sources (write-1-to-clear). Level-type bits are unaffected.
- 1 ENABLE: read/write. Reset value is `EN_RESET`.
- 2 STATUS: read-only. Bits [VEC_W-1:0] = current or in-service vector; bits [17:16] = state code.
- 3 EOI: write of any value ends service. Effective only in INSERVICE; ignored otherwise.
- 4 SOFT: write sets, for each set bit, the pending bit of edge-type sources.
- 5..7: reads return 0; writes are ignored.

Pending logic:
- Edge source: pending sets when `irq_src[i]` rises (0 in the previous cycle, 1 now). It clears on W1C, or on ack of that source.
- Level source: pending equals `irq_src[i]` as registered. It is never latched and is not cleared by ack.
- `eligible` = pending & ENABLE. The winner is the lowest index set in `eligible`.

State machine (reset → IDLE):
- IDLE, code 0: `interrupt_vector` = 0. If `eligible` ≠ 0, load the vector with winner+1 and go to PRESENT.
- PRESENT, code 1: the vector is held stable and locked. It does not change for later arrivals of higher priority or for mask changes. On an `interrupt_ack` rising edge (detected internally with a registered copy of ack): clear the pending bit of the presented source if it is edge-type, drive the vector to 0, remember the in-service id, and go to INSERVICE.
- INSERVICE, code 2: the vector is 0 and no new interrupt is presented. On an EOI write, go to IDLE.

Boundary rules:
- An ack edge seen in IDLE or INSERVICE is ignored.
- A source edge in the same cycle as a W1C or ack-clear of the same bit leaves the bit set (set wins).
- SOFT and W1C writes on the same bit cannot collide, because they use different addresses.
- If a level source is still asserted after EOI, it is re-presented.
- Reset mid-sequence clears pending, the ack history, the in-service id and the vector, reloads ENABLE with `EN_RESET`, and returns to IDLE.

## Timing
- All outputs except `reg_rdata` are registered. Values at reset: `interrupt_vector` = 0, state = IDLE, pending = 0.
- A source edge sampled at cycle N sets pending at N+1. `interrupt_vector` is valid at N+2 if the block is in IDLE.
- An ack rising edge at cycle M gives `interrupt_vector` = 0 at M+1.
- An EOI write at cycle K returns the state to IDLE at K+1. The next vector can appear at K+2.
- A register write takes effect on the next `clk` edge. A read in the same cycle returns the old value.

## Structure
- Shared definitions added to `header.vh`: register offsets (`IRQ_PENDING`..`IRQ_SOFT`), the state codes, and an `Irq_base` bus address beside `Key_base`/`Art_base`.
- One sub-module, `irq_prio_enc`: a combinational lowest-index priority encoder from NUM_SRC bits to VEC_W bits, plus a valid flag. Output is index+1.
- The top-level bus controller decodes `Irq_selected` and drives `reg_wr`/`reg_rd`.

## Test plan
- Reset with `irq_src[2]` high (edge type): no pending after reset deasserts, until a fresh 0→1 transition occurs; then `interrupt_vector` = 3 two cycles later.
- `irq_src[5]` and `irq_src[1]` rise in the same cycle → vector = 2. Ack held for 100 cycles → vector 0 one cycle after the ack edge; STATUS reads state 2, id 2; no re-present during the held ack. EOI → vector = 6 two cycles later.
- In PRESENT with vector 6, `irq_src[0]` rises and ENABLE is written to 0 → vector stays 6 until ack.
- Level source 3 held high through ack and EOI → re-presented as vector 4 after EOI. Dropping it before EOI → IDLE with vector 0.
- SOFT write 0x10 → vector 5. A W1C write 0x10 in the same cycle as a fresh edge on `irq_src[4]` → pending bit 4 remains set.
- Assert `reset` while in INSERVICE → vector 0, PENDING reads 0, ENABLE reads `EN_RESET`, and an ack edge with no pending sources does not change the vector.

Source files
------------

// File: rtl/irq_ctrl_multi_pkg.sv
// Shared definitions for the multi-source interrupt controller: state codes
// and register word offsets.
package irq_ctrl_multi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_PRESENT   = 2'd1,
      ST_INSERVICE = 2'd2
   } irq_state_t;

   localparam logic [2:0] IRQ_PENDING = 3'd0;
   localparam logic [2:0] IRQ_ENABLE  = 3'd1;
   localparam logic [2:0] IRQ_STATUS  = 3'd2;
   localparam logic [2:0] IRQ_EOI     = 3'd3;
   localparam logic [2:0] IRQ_SOFT    = 3'd4;

   localparam int STATUS_STATE_LSB = 16;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational lowest-index priority encoder; output is index+1, 0 when idle.
module irq_prio_enc
   import irq_ctrl_multi_pkg::*;
#(
   parameter int NUM_SRC = 8,
   parameter int VEC_W   = 4
) (
   input  logic [NUM_SRC-1:0] req,
   output logic [VEC_W-1:0]   vec,
   output logic               valid
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      vec   = '0;
      valid = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            vec   = VEC_W'(i + 1);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_ctrl_multi.sv
// Multi-source interrupt controller: pending/enable latching, lowest-index
// priority, and the claim -> in-service -> EOI handshake with the CPU.
module irq_ctrl_multi
   import irq_ctrl_multi_pkg::*;
#(
   parameter int                 NUM_SRC  = 8,
   parameter int                 VEC_W    = 4,
   parameter logic [NUM_SRC-1:0] EDGE_SRC = '1,
   parameter logic [NUM_SRC-1:0] EN_RESET = '1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_SRC-1:0] irq_src,
   output logic [VEC_W-1:0]   interrupt_vector,
   input  logic               interrupt_ack,
   input  logic [2:0]         reg_addr,
   input  logic               reg_wr,
   input  logic [63:0]        reg_wdata,
   input  logic               reg_rd,
   output logic [63:0]        reg_rdata
);

   logic [NUM_SRC-1:0] pending_reg, pending_next;
   logic [NUM_SRC-1:0] enable_reg, enable_next;
   logic [NUM_SRC-1:0] src_prev_reg;
   logic               ack_prev_reg;
   irq_state_t         state_reg, state_next;
   logic [VEC_W-1:0]   vector_reg, vector_next;
   logic [VEC_W-1:0]   id_reg, id_next;

   logic [NUM_SRC-1:0] wdata_src, eligible, claim_mask, set_vec, clr_vec, edge_next;
   logic [VEC_W-1:0]   winner;
   logic               winner_valid, ack_edge, claim;
   logic               wr_pending, wr_enable, wr_eoi, wr_soft;
   logic               unused_wdata;

   assign wdata_src    = reg_wdata[NUM_SRC-1:0];
   assign unused_wdata = ^reg_wdata[63:NUM_SRC];

   assign wr_pending = reg_wr && (reg_addr == IRQ_PENDING);
   assign wr_enable  = reg_wr && (reg_addr == IRQ_ENABLE);
   assign wr_eoi     = reg_wr && (reg_addr == IRQ_EOI);
   assign wr_soft    = reg_wr && (reg_addr == IRQ_SOFT);

   assign ack_edge = interrupt_ack && !ack_prev_reg;
   assign claim    = (state_reg == ST_PRESENT) && ack_edge;

   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_claim
         assign claim_mask[gi] = claim && (vector_reg == VEC_W'(gi + 1));
      end
   endgenerate

   // Sets are applied after clears so a coincident edge/SOFT wins over W1C/ack.
   assign set_vec      = (irq_src & ~src_prev_reg) | (wr_soft ? wdata_src : '0);
   assign clr_vec      = (wr_pending ? wdata_src : '0) | claim_mask;
   assign edge_next    = set_vec | (pending_reg & ~clr_vec);
   assign pending_next = (EDGE_SRC & edge_next) | (~EDGE_SRC & irq_src);
   assign enable_next  = wr_enable ? wdata_src : enable_reg;
   assign eligible     = pending_reg & enable_reg;

   irq_prio_enc #(
      .NUM_SRC (NUM_SRC),
      .VEC_W   (VEC_W)
   ) u_prio_enc (
      .req   (eligible),
      .vec   (winner),
      .valid (winner_valid)
   );

   always_comb begin
      state_next  = state_reg;
      vector_next = vector_reg;
      id_next     = id_reg;
      case (state_reg)
         ST_IDLE: begin
            if (winner_valid) begin
               vector_next = winner;
               state_next  = ST_PRESENT;
            end
         end
         ST_PRESENT: begin
            if (ack_edge) begin
               id_next     = vector_reg;
               vector_next = '0;
               state_next  = ST_INSERVICE;
            end
         end
         ST_INSERVICE: begin
            if (wr_eoi) state_next = ST_IDLE;
         end
         default: begin
            state_next  = ST_IDLE;
            vector_next = '0;
         end
      endcase
   end

   // Previous-source history resets high so a line already asserted across
   // reset needs a fresh 0->1 transition before it counts as an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_reg  <= '0;
         enable_reg   <= EN_RESET;
         src_prev_reg <= '1;
         ack_prev_reg <= 1'b0;
         state_reg    <= ST_IDLE;
         vector_reg   <= '0;
         id_reg       <= '0;
      end else begin
         pending_reg  <= pending_next;
         enable_reg   <= enable_next;
         src_prev_reg <= irq_src;
         ack_prev_reg <= interrupt_ack;
         state_reg    <= state_next;
         vector_reg   <= vector_next;
         id_reg       <= id_next;
      end
   end

   assign interrupt_vector = vector_reg;

   always_comb begin
      reg_rdata = '0;
      if (reg_rd) begin
         case (reg_addr)
            IRQ_PENDING: reg_rdata[NUM_SRC-1:0] = pending_reg;
            IRQ_ENABLE:  reg_rdata[NUM_SRC-1:0] = enable_reg;
            IRQ_STATUS: begin
               reg_rdata[VEC_W-1:0] = (state_reg == ST_INSERVICE) ? id_reg : vector_reg;
               reg_rdata[STATUS_STATE_LSB +: 2] = state_reg;
            end
            default: reg_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_irq_ctrl_multi.sv
// Self-checking bench for irq_ctrl_multi: directed scenarios plus a randomized
// run, all checked against a behavioural model of the controller.
module tb_irq_ctrl_multi;

   localparam int         N    = 8;
   localparam logic [7:0] EDGE = 8'hF7;   // source 3 is level-type
   localparam logic [7:0] ENR  = 8'hFF;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  irq_src = '0;
   logic [3:0]  interrupt_vector;
   logic        interrupt_ack = 1'b0;
   logic [2:0]  reg_addr = '0;
   logic        reg_wr = 1'b0;
   logic [63:0] reg_wdata = '0;
   logic        reg_rd = 1'b0;
   logic [63:0] reg_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model: pending bits, enable, phase 0/1/2, presented and serviced ids.
   logic [7:0] m_pend, m_en, m_prev;
   logic       m_ackprev;
   int         m_phase;
   logic [3:0] m_vec, m_id;

   irq_ctrl_multi #(
      .NUM_SRC  (N),
      .VEC_W    (4),
      .EDGE_SRC (EDGE),
      .EN_RESET (ENR)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .irq_src          (irq_src),
      .interrupt_vector (interrupt_vector),
      .interrupt_ack    (interrupt_ack),
      .reg_addr         (reg_addr),
      .reg_wr           (reg_wr),
      .reg_wdata        (reg_wdata),
      .reg_rd           (reg_rd),
      .reg_rdata        (reg_rdata)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_pend    = '0;
      m_en      = ENR;
      m_prev    = '1;   // a line held high across reset is not a new request
      m_ackprev = 1'b0;
      m_phase   = 0;
      m_vec     = '0;
      m_id      = '0;
   endtask

   function automatic logic [63:0] m_status();
      logic [63:0] s;
      s = '0;
      s[17:16] = 2'(m_phase);
      s[3:0]   = (m_phase == 2) ? m_id : m_vec;
      return s;
   endfunction

   // Advance one clock: model consumes the inputs present before the edge.
   task automatic tick();
      logic [7:0] np, nen;
      logic [3:0] win, nvec, nid;
      int         nph;
      bit         claim;
      if (reset) begin
         @(posedge clk);
         model_reset();
         #1;
         return;
      end
      claim = (m_phase == 1) && interrupt_ack && !m_ackprev;
      for (int i = 0; i < N; i++) begin
         if (EDGE[i]) begin
            np[i] = m_pend[i];
            if (reg_wr && reg_addr == 3'd0 && reg_wdata[i]) np[i] = 1'b0;
            if (claim && m_vec == 4'(i + 1)) np[i] = 1'b0;
            if ((irq_src[i] && !m_prev[i]) || (reg_wr && reg_addr == 3'd4 && reg_wdata[i])) np[i] = 1'b1;
         end else begin
            np[i] = irq_src[i];
         end
      end
      win = '0;
      for (int i = N - 1; i >= 0; i--) if (m_pend[i] && m_en[i]) win = 4'(i + 1);
      nph = m_phase; nvec = m_vec; nid = m_id;
      if (m_phase == 0 && win != 0) begin
         nph = 1; nvec = win;
      end else if (claim) begin
         nph = 2; nid = m_vec; nvec = '0;
      end else if (m_phase == 2 && reg_wr && reg_addr == 3'd3) begin
         nph = 0;
      end
      nen = (reg_wr && reg_addr == 3'd1) ? reg_wdata[7:0] : m_en;
      m_prev    = irq_src;
      m_ackprev = interrupt_ack;
      @(posedge clk);
      m_pend = np; m_en = nen; m_phase = nph; m_vec = nvec; m_id = nid;
      #1;
   endtask

   task automatic wr_reg(input logic [2:0] a, input logic [63:0] d);
      reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
      tick();
      reg_wr = 1'b0;
      $display("wr addr=%0d data=%0h vec=%0d", a, d, interrupt_vector);
   endtask

   task automatic rd_reg(input logic [2:0] a, output logic [63:0] d);
      reg_addr = a; reg_rd = 1'b1;
      #1;
      d = reg_rdata;
      reg_rd = 1'b0;
   endtask

   task automatic service();
      interrupt_ack = 1'b1; tick();
      interrupt_ack = 1'b0; tick();
      wr_reg(3'd3, 64'h0);
      tick();
   endtask

   task automatic test_reset();
      logic [63:0] d;
      irq_src = 8'h04;
      model_reset();
      repeat (3) tick();
      n_checks++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL reset_vec: got %0d want 0", interrupt_vector); end
      rd_reg(3'd0, d);
      n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL reset_pending: got %0h want 0", d); end
      rd_reg(3'd1, d);
      n_checks++; if (d !== 64'hFF) begin n_fail++; $display("FAIL reset_enable: got %0h want ff", d); end
      reg_addr = 3'd1; reg_rd = 1'b0; #1;
      n_checks++; if (reg_rdata !== 64'h0) begin n_fail++; $display("FAIL rdata_no_rd: got %0h want 0", reg_rdata); end
      reset = 1'b0;
      repeat (4) tick();
      rd_reg(3'd0, d);
      n_checks++; if (d !== 64'h0 || interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL held_high_no_edge: pend %0h vec %0d want 0/0", d, interrupt_vector); end
      irq_src = 8'h00; tick();
      irq_src = 8'h04; tick();
      rd_reg(3'd0, d);
      n_checks++; if (d !== 64'h4 || interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL fresh_edge_pend: pend %0h vec %0d want 4/0", d, interrupt_vector); end
      tick();
      n_checks++; if (interrupt_vector !== 4'd3) begin n_fail++; $display("FAIL fresh_edge_vec: got %0d want 3", interrupt_vector); end
      service();
      irq_src = 8'h00; tick();
      $display("test_reset done");
   endtask

   task automatic test_priority_ack();
      logic [63:0] d;
      int bad;
      irq_src = 8'h22; tick(); tick();
      n_checks++; if (interrupt_vector !== 4'd2 || interrupt_vector !== m_vec) begin n_fail++; $display("FAIL prio_vec: got %0d want 2 (model %0d)", interrupt_vector, m_vec); end
      interrupt_ack = 1'b1; tick();
      n_checks++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL ack_vec: got %0d want 0", interrupt_vector); end
      rd_reg(3'd2, d);
      n_checks++; if (d !== 64'h20002) begin n_fail++; $display("FAIL inservice_status: got %0h want 20002", d); end
      bad = 0;
      for (int c = 0; c < 99; c++) begin
         tick();
         if (interrupt_vector !== 4'd0) bad++;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL held_ack_no_present: %0d nonzero cycles want 0", bad); end
      interrupt_ack = 1'b0; tick();
      wr_reg(3'd3, 64'h0);
      rd_reg(3'd2, d);
      n_checks++; if (d !== 64'h0 || interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL eoi_idle: status %0h vec %0d want 0/0", d, interrupt_vector); end
      tick();
      n_checks++; if (interrupt_vector !== 4'd6) begin n_fail++; $display("FAIL eoi_next_vec: got %0d want 6", interrupt_vector); end
      $display("test_priority_ack done");
   endtask

   task automatic test_lock();
      logic [63:0] d;
      irq_src = 8'h23;
      wr_reg(3'd1, 64'h0);
      repeat (3) tick();
      n_checks++; if (interrupt_vector !== 4'd6) begin n_fail++; $display("FAIL locked_vec: got %0d want 6", interrupt_vector); end
      rd_reg(3'd0, d);
      n_checks++; if (d !== 64'h21) begin n_fail++; $display("FAIL locked_pend: got %0h want 21", d); end
      interrupt_ack = 1'b1; tick();
      n_checks++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL locked_ack: got %0d want 0", interrupt_vector); end
      interrupt_ack = 1'b0; tick();
      wr_reg(3'd3, 64'h0);
      tick(); tick();
      n_checks++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL masked_idle: got %0d want 0", interrupt_vector); end
      wr_reg(3'd1, 64'hFF);
      tick();
      n_checks++; if (interrupt_vector !== 4'd1) begin n_fail++; $display("FAIL unmask_vec: got %0d want 1", interrupt_vector); end
      service();
      irq_src = 8'h00; tick();
      $display("test_lock done");
   endtask

   task automatic test_level();
      logic [63:0] d;
      irq_src = 8'h08; tick(); tick();
      n_checks++; if (interrupt_vector !== 4'd4) begin n_fail++; $display("FAIL level_vec: got %0d want 4", interrupt_vector); end
      interrupt_ack = 1'b1; tick();
      n_checks++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL level_ack: got %0d want 0", interrupt_vector); end
      interrupt_ack = 1'b0; tick();
      wr_reg(3'd3, 64'h0);
      tick();
      n_checks++; if (interrupt_vector !== 4'd4) begin n_fail++; $display("FAIL level_represent: got %0d want 4", interrupt_vector); end
      interrupt_ack = 1'b1; tick();
      interrupt_ack = 1'b0; irq_src = 8'h00; tick();
      wr_reg(3'd3, 64'h0);
      tick(); tick();
      rd_reg(3'd2, d);
      n_checks++; if (interrupt_vector !== 4'd0 || d !== 64'h0) begin n_fail++; $display("FAIL level_drop: vec %0d status %0h want 0/0", interrupt_vector, d); end
      $display("test_level done");
   endtask

   task automatic test_soft_w1c();
      logic [63:0] d;
      wr_reg(3'd4, 64'h10);
      tick();
      n_checks++; if (interrupt_vector !== 4'd5) begin n_fail++; $display("FAIL soft_vec: got %0d want 5", interrupt_vector); end
      service();
      rd_reg(3'd0, d);
      n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL ack_clear: got %0h want 0", d); end
      irq_src = 8'h10;
      wr_reg(3'd0, 64'h10);
      rd_reg(3'd0, d);
      n_checks++; if (d !== 64'h10) begin n_fail++; $display("FAIL set_wins: got %0h want 10", d); end
      wr_reg(3'd4, 64'h88);
      rd_reg(3'd0, d);
      n_checks++; if (d !== 64'h90) begin n_fail++; $display("FAIL soft_edge_only: got %0h want 90", d); end
      wr_reg(3'd0, 64'h80);
      rd_reg(3'd0, d);
      n_checks++; if (d !== 64'h10 || interrupt_vector !== 4'd5) begin n_fail++; $display("FAIL w1c: pend %0h vec %0d want 10/5", d, interrupt_vector); end
      service();
      irq_src = 8'h00; tick();
      $display("test_soft_w1c done");
   endtask

   task automatic test_reset_midseq();
      logic [63:0] d;
      irq_src = 8'h40; tick(); tick();
      n_checks++; if (interrupt_vector !== 4'd7) begin n_fail++; $display("FAIL pre_reset_vec: got %0d want 7", interrupt_vector); end
      wr_reg(3'd1, 64'h4F);
      wr_reg(3'd4, 64'h01);
      interrupt_ack = 1'b1; tick();
      interrupt_ack = 1'b0;
      rd_reg(3'd2, d);
      n_checks++; if (d !== 64'h20007) begin n_fail++; $display("FAIL pre_reset_status: got %0h want 20007", d); end
      irq_src = 8'h00;
      reset = 1'b1;
      #1;
      model_reset();
      n_checks++; if (interrupt_vector !== 4'd0) begin n_fail++; $display("FAIL midreset_vec: got %0d want 0", interrupt_vector); end
      rd_reg(3'd0, d);
      n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL midreset_pend: got %0h want 0", d); end
      rd_reg(3'd1, d);
      n_checks++; if (d !== 64'hFF) begin n_fail++; $display("FAIL midreset_enable: got %0h want ff", d); end
      tick(); tick();
      reset = 1'b0;
      interrupt_ack = 1'b1;
      repeat (3) tick();
      rd_reg(3'd2, d);
      n_checks++; if (interrupt_vector !== 4'd0 || d !== 64'h0) begin n_fail++; $display("FAIL post_reset_ack: vec %0d status %0h want 0/0", interrupt_vector, d); end
      interrupt_ack = 1'b0; tick();
      $display("test_reset_midseq done");
   endtask

   task automatic test_random();
      logic [2:0]  a;
      logic [63:0] d, exp;
      for (int c = 0; c < 1500; c++) begin
         a = 3'($urandom_range(0, 7));
         rd_reg(a, d);
         case (a)
            3'd0:    exp = {56'h0, m_pend};
            3'd1:    exp = {56'h0, m_en};
            3'd2:    exp = m_status();
            default: exp = 64'h0;
         endcase
         n_checks++; if (d !== exp) begin n_fail++; $display("FAIL rand_read cyc %0d addr %0d: got %0h want %0h", c, a, d, exp); end
         for (int i = 0; i < N; i++) if ($urandom_range(0, 11) == 0) irq_src[i] = ~irq_src[i];
         if ($urandom_range(0, 6) == 0) interrupt_ack = ~interrupt_ack;
         reg_wr    = ($urandom_range(0, 4) == 0);
         reg_addr  = 3'($urandom_range(0, 7));
         reg_wdata = {32'($urandom), 32'($urandom)};
         if (reg_wr) $display("rand wr cyc %0d addr=%0d data=%0h", c, reg_addr, reg_wdata);
         tick();
         reg_wr = 1'b0;
         n_checks++; if (interrupt_vector !== m_vec) begin n_fail++; $display("FAIL rand_vec cyc %0d: got %0d want %0d", c, interrupt_vector, m_vec); end
      end
      irq_src = '0; interrupt_ack = 1'b0;
      tick();
      $display("test_random done");
   endtask

   initial begin
      test_reset();
      test_priority_ack();
      test_lock();
      test_level();
      test_soft_w1c();
      test_reset_midseq();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
